// File: rtl/pool2x2_stream_if.sv
// ---------------------------------------------------------------------------
// pool2x2_stream_if
// Stream bundle between a pixel source/sink and the 2x2 pooling controller.
//   in_valid  : source has a pixel on in_pix
//   in_ready  : controller takes in_pix this cycle
//   in_pix    : input pixel, raster order, plane 0 first
//   out_valid : controller has a pooled pixel on out_pix
//   out_ready : sink takes out_pix this cycle
//   out_pix   : pooled pixel, raster order per plane
// The controller connects through the slave modport; the environment that
// feeds pixels and consumes results connects through the master modport.
// ---------------------------------------------------------------------------
interface pool2x2_stream_if #(
    parameter int PW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pix;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pix;

    modport slave (
        input  in_valid,
        input  in_pix,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pix
    );

    modport master (
        output in_valid,
        output in_pix,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pix
    );
endinterface

// File: rtl/pool2x2_stream_ctrl.sv
// ---------------------------------------------------------------------------
// pool2x2_stream_ctrl
// Sequencer for 2x2 second-largest pooling. Takes a planar raster stream of
// CH planes of N x N pixels, buffers each even row, assembles every 2x2
// window, presents it to an external combinational second_largest unit and
// emits the (N/2)x(N/2)xCH result stream with valid/ready flow control.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i             : frame start pulse, only honoured while idle
//   strm (slave)        : input/output pixel streams (see pool2x2_stream_if)
//   win_in1_o..win_in4_o: registered window TL, TR, BL, BR to second_largest
//   win_out_i           : second_largest result for the current window
//   busy_o              : high while a frame is in progress
//   done_o              : one-cycle pulse after the last pooled pixel is taken
// ---------------------------------------------------------------------------
module pool2x2_stream_ctrl #(
    parameter int N  = 512,
    parameter int CH = 3,
    parameter int PW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    pool2x2_stream_if.slave strm,
    output logic [PW-1:0]   win_in1_o,
    output logic [PW-1:0]   win_in2_o,
    output logic [PW-1:0]   win_in3_o,
    output logic [PW-1:0]   win_in4_o,
    input  logic [PW-1:0]   win_out_i,
    output logic            busy_o,
    output logic            done_o
);
    localparam int CW  = $clog2(N);
    localparam int CHW = $clog2(CH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0]  POS_LAST = CW'(N - 1);
    localparam logic [CW-1:0]  POS_ONE  = CW'(1);
    localparam logic [CW-1:0]  POS_ZERO = {CW{1'b0}};
    localparam logic [CHW-1:0] CH_ALL   = CHW'(CH);
    localparam logic [CHW-1:0] CH_ONE   = CHW'(1);
    localparam logic [CHW-1:0] CH_ZERO  = {CHW{1'b0}};

    logic [1:0]     state_q,     state_d;
    logic [CW-1:0]  col_q,       col_d;
    logic [CW-1:0]  row_q,       row_d;
    logic [CHW-1:0] ch_q,        ch_d;
    logic           pend_q,      pend_d;
    logic           out_valid_q, out_valid_d;
    logic [PW-1:0]  out_pix_q,   out_pix_d;
    logic [PW-1:0]  hold_q,      hold_d;
    logic [PW-1:0]  win1_q,      win1_d;
    logic [PW-1:0]  win2_q,      win2_d;
    logic [PW-1:0]  win3_q,      win3_d;
    logic [PW-1:0]  win4_q,      win4_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;

    // Even-row storage; contents are don't-care after reset.
    logic [PW-1:0]  linebuf_q [N];

    logic           all_in_s;
    logic           out_hs_s;
    logic           in_ready_s;
    logic           accept_s;
    logic           close_s;
    logic           last_out_s;
    logic [CW-1:0]  col_prev_s;

    // ch reaching CH means every pixel of the frame has been taken.
    assign all_in_s   = (ch_q == CH_ALL);
    assign out_hs_s   = out_valid_q & strm.out_ready;
    // A blocked output register or a pending window stalls the input so no
    // result can be overwritten before the sink has taken it.
    assign in_ready_s = (state_q == ST_RUN) & ~pend_q
                      & ~(out_valid_q & ~strm.out_ready) & ~all_in_s;
    assign accept_s   = strm.in_valid & in_ready_s;
    assign close_s    = accept_s & row_q[0] & col_q[0];
    // Once all input is in and no window is pending, the valid output is
    // necessarily the final pooled pixel of the frame.
    assign last_out_s = (state_q == ST_RUN) & out_hs_s & all_in_s & ~pend_q;
    // Closing pixels sit on odd columns, so col-1 is the window's left column.
    assign col_prev_s = col_q - POS_ONE;

    // Frame state machine and raster position counters.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    col_d   = POS_ZERO;
                    row_d   = POS_ZERO;
                    ch_d    = CH_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_out_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept_s) begin
            if (col_q == POS_LAST) begin
                col_d = POS_ZERO;
                if (row_q == POS_LAST) begin
                    row_d = POS_ZERO;
                    ch_d  = ch_q + CH_ONE;
                end else begin
                    row_d = row_q + POS_ONE;
                end
            end else begin
                col_d = col_q + POS_ONE;
            end
        end else begin
            col_d = col_d;
        end
    end

    // Window assembly, pending flag and output register next state.
    always_comb begin
        pend_d      = 1'b0;
        hold_d      = hold_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        win3_d      = win3_q;
        win4_d      = win4_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        if (accept_s & row_q[0] & ~col_q[0]) begin
            hold_d = strm.in_pix;
        end else begin
            hold_d = hold_q;
        end
        if (close_s) begin
            win1_d = linebuf_q[col_prev_s];
            win2_d = linebuf_q[col_q];
            win3_d = hold_q;
            win4_d = strm.in_pix;
            pend_d = 1'b1;
        end else begin
            pend_d = 1'b0;
        end
        // The cycle after a closing pixel the window registers are stable, so
        // the combinational second_largest result is captured here.
        if (pend_q) begin
            out_valid_d = 1'b1;
            out_pix_d   = win_out_i;
        end else if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= POS_ZERO;
            row_q       <= POS_ZERO;
            ch_q        <= CH_ZERO;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pix_q   <= {PW{1'b0}};
            hold_q      <= {PW{1'b0}};
            win1_q      <= {PW{1'b0}};
            win2_q      <= {PW{1'b0}};
            win3_q      <= {PW{1'b0}};
            win4_q      <= {PW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            hold_q      <= hold_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            win3_q      <= win3_d;
            win4_q      <= win4_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Line buffer write on every accepted even-row pixel.
    always_ff @(posedge clk) begin
        if (accept_s & ~row_q[0]) begin
            linebuf_q[col_q] <= strm.in_pix;
        end
    end

    assign strm.in_ready  = in_ready_s;
    assign strm.out_valid = out_valid_q;
    assign strm.out_pix   = out_pix_q;
    assign win_in1_o      = win1_q;
    assign win_in2_o      = win2_q;
    assign win_in3_o      = win3_q;
    assign win_in4_o      = win4_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_pool2x2_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pool2x2_stream_ctrl
// Two controllers (N=4,CH=1 and N=8,CH=3) share the stimulus; sel picks which
// one receives start and is observed. Expected pooled pixels come from a
// frame-level model (sort each 2x2 window, take the second entry).
// ---------------------------------------------------------------------------
module tb_pool2x2_stream_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_pix = 4'd0;
    logic out_ready = 1'b0;
    logic sel = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int nn_cur = 4;
    int cc_cur = 1;

    logic [3:0] frame [192];
    logic [3:0] exp_q [$];
    logic [3:0] got_q [$];

    always #5 clk = ~clk;

    pool2x2_stream_if #(.PW(4)) sif4 ();
    pool2x2_stream_if #(.PW(4)) sif8 ();

    logic st4, st8, b4, b8, d4, d8;
    logic [3:0] w4_1, w4_2, w4_3, w4_4, wo4;
    logic [3:0] w8_1, w8_2, w8_3, w8_4, wo8;

    assign st4 = start & ~sel;
    assign st8 = start & sel;
    assign sif4.in_valid  = in_valid;
    assign sif4.in_pix    = in_pix;
    assign sif4.out_ready = out_ready;
    assign sif8.in_valid  = in_valid;
    assign sif8.in_pix    = in_pix;
    assign sif8.out_ready = out_ready;

    // Behavioural second_largest unit: sort descending, take second entry.
    function automatic logic [3:0] sl2(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        logic [3:0] v [4];
        logic [3:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[1];
    endfunction

    always_comb wo4 = sl2(w4_1, w4_2, w4_3, w4_4);
    always_comb wo8 = sl2(w8_1, w8_2, w8_3, w8_4);

    pool2x2_stream_ctrl #(.N(4), .CH(1), .PW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(st4), .strm(sif4),
        .win_in1_o(w4_1), .win_in2_o(w4_2), .win_in3_o(w4_3), .win_in4_o(w4_4),
        .win_out_i(wo4), .busy_o(b4), .done_o(d4));

    pool2x2_stream_ctrl #(.N(8), .CH(3), .PW(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(st8), .strm(sif8),
        .win_in1_o(w8_1), .win_in2_o(w8_2), .win_in3_o(w8_3), .win_in4_o(w8_4),
        .win_out_i(wo8), .busy_o(b8), .done_o(d8));

    logic m_in_ready, m_out_valid, m_busy_o, m_done_o;
    logic [3:0] m_out_pix, m_w1, m_w2, m_w3, m_w4;
    assign m_in_ready  = sel ? sif8.in_ready  : sif4.in_ready;
    assign m_out_valid = sel ? sif8.out_valid : sif4.out_valid;
    assign m_out_pix   = sel ? sif8.out_pix   : sif4.out_pix;
    assign m_busy_o    = sel ? b8 : b4;
    assign m_done_o    = sel ? d8 : d4;
    assign m_w1 = sel ? w8_1 : w4_1;
    assign m_w2 = sel ? w8_2 : w4_2;
    assign m_w3 = sel ? w8_3 : w4_3;
    assign m_w4 = sel ? w8_4 : w4_4;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Frame model: one expected pooled pixel per 2x2 window, plane by plane.
    task automatic build_expect();
        int b;
        for (int p = 0; p < cc_cur; p++)
            for (int r = 0; r < nn_cur / 2; r++)
                for (int c = 0; c < nn_cur / 2; c++) begin
                    b = p * nn_cur * nn_cur + 2 * r * nn_cur + 2 * c;
                    exp_q.push_back(sl2(frame[b], frame[b+1], frame[b+nn_cur], frame[b+nn_cur+1]));
                end
    endtask

    // Per-cycle compare process against the model.
    task automatic compare_loop();
        bit m_busy = 1'b0;
        bit m_done = 1'b0;
        bit nb, nd, hs, last, prev_stall;
        logic [3:0] prev_pix;
        prev_stall = 1'b0;
        prev_pix = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_busy = 1'b0; m_done = 1'b0; prev_stall = 1'b0;
            end else begin
                chk("busy", m_busy_o, m_busy);
                chk("done", m_done_o, m_done);
                if (!m_busy) chk("in_ready_not_running", m_in_ready, 1'b0);
                if (m_out_valid && !out_ready) chk("in_ready_backpressure", m_in_ready, 1'b0);
                if (prev_stall) begin
                    chk("hold_valid", m_out_valid, 1'b1);
                    chk("hold_pix", m_out_pix, prev_pix);
                end
                if (m_out_valid) begin
                    if (exp_q.size() == 0) chk("spurious_out", m_out_valid, 1'b0);
                    else chk("out_pix", m_out_pix, exp_q[0]);
                end
                hs = m_out_valid && out_ready;
                last = hs && m_busy && (exp_q.size() == 1);
                nd = last;
                if (m_busy) nb = !last;
                else nb = start && !m_done;
                if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
                prev_stall = m_out_valid && !out_ready;
                prev_pix = m_out_pix;
                m_busy = nb; m_done = nd;
            end
        end
    endtask

    // Runs one frame from frame[]; rmode 0 ready, 1 random, 2 stall after 1st result.
    task automatic run_frame(input bit gaps, input int rmode, input int abort_at, input bit start_mid);
        int idx, total, nout, nexp, cyc, stall_cnt, hs_cyc, done_cyc;
        bit fin, stall_on, aborted;
        idx = 0; nout = 0; cyc = 0; stall_cnt = 0; hs_cyc = -100; done_cyc = 0;
        fin = 1'b0; stall_on = 1'b0; aborted = 1'b0;
        total = nn_cur * nn_cur * cc_cur;
        nexp = (nn_cur / 2) * (nn_cur / 2) * cc_cur;
        got_q.delete();
        @(posedge clk); #1; start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        while (!fin && !aborted && cyc < 4000) begin
            if (idx < total) begin
                in_pix = frame[idx];
                in_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            end else begin
                in_valid = 1'b0; in_pix = 4'd0;
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(1, 0));
                default: begin
                    if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
                    else out_ready = stall_on;
                end
            endcase
            start = start_mid && (cyc == 6);
            @(negedge clk);
            if (rmode == 2 && stall_on && !out_ready) begin
                chk("stall_pix", m_out_pix, 4'd5);
                chk("stall_in_ready", m_in_ready, 1'b0);
            end
            if (in_valid && m_in_ready) idx++;
            if (m_out_valid && out_ready) begin
                got_q.push_back(m_out_pix);
                nout++;
                if (nout == nexp) hs_cyc = cyc;
            end
            if (rmode == 2 && !stall_on && m_out_valid) begin stall_on = 1'b1; stall_cnt = 10; end
            if (m_done_o) begin fin = 1'b1; done_cyc = cyc; end
            if (abort_at > 0 && nout == abort_at) aborted = 1'b1;
            if (!fin && !aborted) begin @(posedge clk); #1; cyc++; end
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk); #1; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            chk("abort_in_ready", m_in_ready, 1'b0);
            chk("abort_out_valid", m_out_valid, 1'b0);
            chk("abort_out_pix", m_out_pix, 4'd0);
            chk("abort_win1", m_w1, 4'd0);
            chk("abort_win2", m_w2, 4'd0);
            chk("abort_win3", m_w3, 4'd0);
            chk("abort_win4", m_w4, 4'd0);
            chk("abort_busy", m_busy_o, 1'b0);
            chk("abort_done", m_done_o, 1'b0);
            @(posedge clk); #1; rst_n = 1'b1;
        end else begin
            chk("frame_done_seen", fin, 1'b1);
            chk("pixels_accepted", idx, total);
            chk("outputs_taken", nout, nexp);
            chk("done_latency", done_cyc - hs_cyc, 1);
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_lit(input string nm, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        logic [3:0] lit [4];
        lit[0] = a; lit[1] = b; lit[2] = c; lit[3] = d;
        chk({nm, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk(nm, got_q[i], lit[i]);
    endtask

    task automatic load16(input logic [3:0] v [16]);
        for (int i = 0; i < 16; i++) frame[i] = v[i];
    endtask

    logic [3:0] f1 [16];
    logic [3:0] f2 [16];

    initial begin
        f1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
               4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        f2 = '{4'd7, 4'd7, 4'd0, 4'd0, 4'd3, 4'd1, 4'd0, 4'd0,
               4'd15, 4'd15, 4'd2, 4'd9, 4'd15, 4'd15, 4'd9, 4'd4};
        fork
            compare_loop();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", m_in_ready, 1'b0);
        chk("rst_out_valid", m_out_valid, 1'b0);
        chk("rst_out_pix", m_out_pix, 4'd0);
        chk("rst_win1", m_w1, 4'd0);
        chk("rst_win2", m_w2, 4'd0);
        chk("rst_win3", m_w3, 4'd0);
        chk("rst_win4", m_w4, 4'd0);
        chk("rst_busy", m_busy_o, 1'b0);
        chk("rst_done", m_done_o, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;

        // in_valid while idle must be ignored.
        in_valid = 1'b1; in_pix = 4'd9; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_in_ready", m_in_ready, 1'b0);
        chk("idle_busy", m_busy_o, 1'b0);
        @(posedge clk); #1; in_valid = 1'b0;

        // Basic frame, with a stray start mid-frame.
        load16(f1); build_expect();
        run_frame(1'b0, 0, 0, 1'b1);
        check_lit("t1_out", 4'd5, 4'd7, 4'd13, 4'd12);

        // Duplicates and extreme windows; window regs hold the last window.
        load16(f2); build_expect();
        run_frame(1'b0, 0, 0, 1'b0);
        check_lit("t2_out", 4'd7, 4'd0, 4'd15, 4'd9);
        chk("t2_win1_hold", m_w1, 4'd2);
        chk("t2_win2_hold", m_w2, 4'd9);
        chk("t2_win3_hold", m_w3, 4'd9);
        chk("t2_win4_hold", m_w4, 4'd4);

        // Downstream stall after first result.
        load16(f1); build_expect();
        run_frame(1'b0, 2, 0, 1'b0);
        check_lit("t3_out", 4'd5, 4'd7, 4'd13, 4'd12);

        // Reset at the second output, then a clean frame.
        load16(f1); build_expect();
        run_frame(1'b0, 0, 2, 1'b0);
        load16(f1); build_expect();
        run_frame(1'b0, 0, 0, 1'b0);
        check_lit("t5_out", 4'd5, 4'd7, 4'd13, 4'd12);

        // N=8, CH=3 with random input gaps and random backpressure.
        sel = 1'b1; nn_cur = 8; cc_cur = 3;
        @(posedge clk); #1;
        for (int i = 0; i < 192; i++) frame[i] = 4'($urandom_range(15, 0));
        build_expect();
        run_frame(1'b1, 1, 0, 1'b0);
        chk("t4_out_count", got_q.size(), 48);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
